otter_fetch_stage: RTL and testbench
====================================

OTTER_FETCH_STAGE -- requirements
Module: otter_fetch_stage

Interface
REQ-001 The block SHALL have exactly the ports REQ-002 to REQ-015.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset; one clock, asynchronous, active-high.
REQ-004 PC_SOURCE  in  2  next-PC select from the branch condition generator: 00 PC+4, 01 JALR, 10 branch, 11 JAL.
REQ-005 EX_VALID  in  1  PC_SOURCE and the three targets are meaningful this cycle.
REQ-006 JALR_TGT, BRANCH_TGT, JAL_TGT  in  32 each  redirect targets from execute.
REQ-007 STALL  in  1  hazard-unit hold of the IF/ID register.
REQ-008 IMEM_REQ  out  1  instruction-memory read request.
REQ-009 IMEM_ADDR  out  32  read address.
REQ-010 IMEM_ACK  in  1  read data valid this cycle; only meaningful while a request is outstanding.
REQ-011 IMEM_RDATA  in  32  instruction word.
REQ-012 IF_ID_PC  out  32  PC of the decode-stage instruction.
REQ-013 IF_ID_IR  out  32  decode-stage instruction word.
REQ-014 IF_ID_VALID  out  1  decode stage holds a live instruction.
REQ-015 FLUSH  out  1  one-cycle pulse telling downstream stages to squash; equal to REDIRECT.

Function
REQ-016 REDIRECT SHALL be EX_VALID AND (PC_SOURCE != 00).
REQ-017 The redirect target SHALL be JALR_TGT, BRANCH_TGT or JAL_TGT for PC_SOURCE 01, 10 and 11; bits [1:0] of the target SHALL be forced to 00.
REQ-018 Sequential next PC SHALL be PC+4 modulo 2^32; 0xFFFFFFFC SHALL wrap to 0x00000000.
REQ-019 The FSM SHALL have three states:
- FETCH: request outstanding.
- HOLD: response parked in the skid buffer.
- DISCARD: waiting for the response of a squashed request.
REQ-020 IMEM_REQ SHALL be 1 only in FETCH; IMEM_ADDR SHALL equal PC and SHALL stay constant while IMEM_REQ=1 and IMEM_ACK=0.
REQ-021 FETCH with ACK, no REDIRECT and STALL=0:
- IF_ID SHALL load {PC, RDATA, VALID=1} on the next edge.
- PC SHALL become PC+4.
- The FSM SHALL stay in FETCH.
- Latency from ACK to IF_ID_VALID SHALL be one cycle.
REQ-022 FETCH with ACK, no REDIRECT and STALL=1:
- {PC, RDATA} SHALL go into a one-entry skid buffer.
- PC SHALL become PC+4.
- The FSM SHALL go to HOLD.
- IF_ID SHALL hold its contents.
REQ-023 HOLD with STALL=0 and no REDIRECT: IF_ID SHALL load the skid entry with VALID=1, and the FSM SHALL go to FETCH.
REQ-024 FETCH without ACK and STALL=0: IF_ID_VALID SHALL become 0 (bubble).
REQ-025 FETCH without ACK and STALL=1: IF_ID SHALL hold its contents.
REQ-026 REDIRECT SHALL take priority over STALL and ACK:
- PC SHALL take the target.
- IF_ID_VALID SHALL become 0.
- The skid entry SHALL be invalidated.
- The FSM SHALL go to DISCARD if it is in FETCH with no ACK this cycle, else to FETCH.
- An ACK in the same cycle SHALL be dropped.
REQ-027 DISCARD: IMEM_REQ=0; on ACK the data SHALL be dropped and the FSM SHALL go to FETCH using the already-updated PC.
REQ-028 REDIRECT while in DISCARD SHALL update PC and SHALL keep the FSM in DISCARD until the ACK arrives.
REQ-029 FLUSH SHALL be combinational and equal to REDIRECT.

Reset
REQ-030 While RST=1, regardless of CLK:
- PC=0x00000000.
- FSM=FETCH.
- Skid buffer empty.
- IF_ID_PC=0, IF_ID_IR=0x00000013 (NOP), IF_ID_VALID=0.
REQ-031 A response arriving in the first cycle after reset deassertion, for a request issued before reset, SHALL be indistinguishable from a fresh ACK; memory SHALL be reset together with this block.

Structure
REQ-032 Shared package otter_pkg SHALL hold:
- pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL);
- fetch_state_t;
- RESET_VECTOR = 32'h0;
- NOP_INSTR = 32'h00000013.
REQ-033 One combinational sub-module otter_pc_sel SHALL compute the next PC from PC_SOURCE, the targets and PC+4; FSM, skid buffer and IF/ID register SHALL stay in otter_fetch_stage.

Verification
REQ-034 Reset, then ACK every cycle, no stall -> IMEM_ADDR 0,4,8,12; IF_ID_PC follows one cycle behind; IF_ID_VALID=1 from the second cycle on.
REQ-035 STALL=1 for 3 cycles with ACK at PC=0x8, IR=0xABCD0013 -> FSM HOLD, IMEM_REQ=0, IF_ID unchanged; first cycle after STALL=0 -> IF_ID={0x8, 0xABCD0013, 1}, next IMEM_ADDR=0xC.
REQ-036 EX_VALID=1, PC_SOURCE=10, BRANCH_TGT=0x103, request at 0x20 not acked -> FLUSH=1, IF_ID_VALID=0, DISCARD; late ACK dropped; next IMEM_ADDR=0x100.
REQ-037 REDIRECT (JAL, JAL_TGT=0x40) in the same cycle as ACK and STALL=1 -> data dropped, skid empty, FSM FETCH, IMEM_ADDR=0x40.
REQ-038 PC=0xFFFFFFFC, ACK, no stall -> next IMEM_ADDR=0x00000000.
REQ-039 RST asserted mid-HOLD -> all outputs take the REQ-030 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch stage.
package otter_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_src_t;

  // StFetch: request outstanding; StHold: response parked in skid buffer;
  // StDiscard: waiting for the response of a squashed request.
  typedef enum logic [1:0] {
    StFetch   = 2'b00,
    StHold    = 2'b01,
    StDiscard = 2'b10
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // Instructions are word aligned; drop the low two bits of a jump target.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_fetch_stage_if.sv
// Instruction-memory read port shared by the fetch stage and the memory.
interface otter_fetch_stage_if;

  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_ACK,
    output IMEM_RDATA
  );

endinterface

// File: rtl/otter_pc_sel.sv
// Next-PC multiplexer: PC+4 or one of the execute-stage redirect targets.
module otter_pc_sel
  import otter_pkg::*;
(
  input  pc_src_t     pc_source_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] jalr_tgt_i,
  input  logic [31:0] branch_tgt_i,
  input  logic [31:0] jal_tgt_i,
  output logic [31:0] next_pc_o
);

  // Select the next PC; redirect targets are forced word aligned.
  always_comb begin
    next_pc_o = pc_plus4_i;
    unique case (pc_source_i)
      PC_PLUS4:  next_pc_o = pc_plus4_i;
      PC_JALR:   next_pc_o = align_word(jalr_tgt_i);
      PC_BRANCH: next_pc_o = align_word(branch_tgt_i);
      PC_JAL:    next_pc_o = align_word(jal_tgt_i);
    endcase
  end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: PC, memory handshake FSM, one-entry skid buffer
// and the IF/ID pipeline register.
module otter_fetch_stage
  import otter_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [1:0]                 PC_SOURCE,
  input  logic                       EX_VALID,
  input  logic [31:0]                JALR_TGT,
  input  logic [31:0]                BRANCH_TGT,
  input  logic [31:0]                JAL_TGT,
  input  logic                       STALL,
  otter_fetch_stage_if.master        imem,
  output logic [31:0]                IF_ID_PC,
  output logic [31:0]                IF_ID_IR,
  output logic                       IF_ID_VALID,
  output logic                       FLUSH
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         redirect;
  logic         ack;

  // The skid entry is live exactly while the FSM is in StHold.
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_ir_q, skid_ir_d;

  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_ir_q, if_id_ir_d;
  logic         if_id_valid_q, if_id_valid_d;

  assign redirect = EX_VALID && (PC_SOURCE != 2'b00);
  assign pc_plus4 = pc_q + 32'd4;
  assign ack      = imem.IMEM_ACK;

  otter_pc_sel u_pc_sel (
    .pc_source_i  (pc_src_t'(PC_SOURCE)),
    .pc_plus4_i   (pc_plus4),
    .jalr_tgt_i   (JALR_TGT),
    .branch_tgt_i (BRANCH_TGT),
    .jal_tgt_i    (JAL_TGT),
    .next_pc_o    (redirect_pc)
  );

  // Next-state logic: redirect overrides everything, else the handshake FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_pc_d     = skid_pc_q;
    skid_ir_d     = skid_ir_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_ir_d    = if_id_ir_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect) begin
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
      // A request still in flight must have its response swallowed.
      if ((state_q == StFetch || state_q == StDiscard) && !ack) begin
        state_d = StDiscard;
      end else begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack) begin
            pc_d = pc_plus4;
            if (STALL) begin
              skid_pc_d = pc_q;
              skid_ir_d = imem.IMEM_RDATA;
              state_d   = StHold;
            end else begin
              if_id_pc_d    = pc_q;
              if_id_ir_d    = imem.IMEM_RDATA;
              if_id_valid_d = 1'b1;
            end
          end else if (!STALL) begin
            if_id_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!STALL) begin
            if_id_pc_d    = skid_pc_q;
            if_id_ir_d    = skid_ir_q;
            if_id_valid_d = 1'b1;
            state_d       = StFetch;
          end
        end
        StDiscard: begin
          if (ack) begin
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StFetch;
      pc_q          <= RESET_VECTOR;
      skid_pc_q     <= 32'h0;
      skid_ir_q     <= NOP_INSTR;
      if_id_pc_q    <= 32'h0;
      if_id_ir_q    <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_ir_q     <= skid_ir_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_ir_q    <= if_id_ir_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem.IMEM_REQ  = (state_q == StFetch);
  assign imem.IMEM_ADDR = pc_q;
  assign IF_ID_PC       = if_id_pc_q;
  assign IF_ID_IR       = if_id_ir_q;
  assign IF_ID_VALID    = if_id_valid_q;
  assign FLUSH          = redirect;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage; the bench plays instruction memory.
module tb_otter_fetch_stage;

  logic        CLK;
  logic        RST;
  logic [1:0]  PC_SOURCE;
  logic        EX_VALID;
  logic [31:0] JALR_TGT, BRANCH_TGT, JAL_TGT;
  logic        STALL;
  logic [31:0] IF_ID_PC, IF_ID_IR;
  logic        IF_ID_VALID;
  logic        FLUSH;

  int checks;
  int failures;

  otter_fetch_stage_if imem_if ();

  otter_fetch_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC_SOURCE   (PC_SOURCE),
    .EX_VALID    (EX_VALID),
    .JALR_TGT    (JALR_TGT),
    .BRANCH_TGT  (BRANCH_TGT),
    .JAL_TGT     (JAL_TGT),
    .STALL       (STALL),
    .imem        (imem_if.master),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_IR    (IF_ID_IR),
    .IF_ID_VALID (IF_ID_VALID),
    .FLUSH       (FLUSH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_defaults();
    PC_SOURCE  = 2'b00;
    EX_VALID   = 1'b0;
    JALR_TGT   = 32'h0;
    BRANCH_TGT = 32'h0;
    JAL_TGT    = 32'h0;
    STALL      = 1'b0;
    imem_if.IMEM_ACK   = 1'b0;
    imem_if.IMEM_RDATA = 32'h0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    set_defaults();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    RST = 1'b1;
    #3;
    checks++; if (imem_if.IMEM_REQ !== 1'b1) begin failures++;
      $display("FAIL reset_req: got %b expected 1", imem_if.IMEM_REQ); end
    checks++; if (imem_if.IMEM_ADDR !== 32'h0) begin failures++;
      $display("FAIL reset_addr: got %h expected 00000000", imem_if.IMEM_ADDR); end
    checks++; if (IF_ID_PC !== 32'h0) begin failures++;
      $display("FAIL reset_if_id_pc: got %h expected 00000000", IF_ID_PC); end
    checks++; if (IF_ID_IR !== 32'h0000_0013) begin failures++;
      $display("FAIL reset_if_id_ir: got %h expected 00000013", IF_ID_IR); end
    checks++; if (IF_ID_VALID !== 1'b0) begin failures++;
      $display("FAIL reset_if_id_valid: got %b expected 0", IF_ID_VALID); end
    checks++; if (FLUSH !== 1'b0) begin failures++;
      $display("FAIL reset_flush: got %b expected 0", FLUSH); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // ACK every cycle; a JAL select without EX_VALID must not redirect.
  task automatic test_sequential();
    logic [31:0] exp_addr, exp_ir;
    reset_dut();
    PC_SOURCE = 2'b11;
    JAL_TGT   = 32'h40;
    imem_if.IMEM_ACK = 1'b1;
    checks++; if (IF_ID_VALID !== 1'b0) begin failures++;
      $display("FAIL seq_first_valid: got %b expected 0", IF_ID_VALID); end
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'(i * 4);
      exp_ir   = 32'h00A0_0013 + 32'(i << 12);
      imem_if.IMEM_RDATA = exp_ir;
      #1;
      checks++; if (imem_if.IMEM_ADDR !== exp_addr || FLUSH !== 1'b0) begin failures++;
        $display("FAIL seq_addr[%0d]: got addr %h flush %b expected addr %h flush 0",
                 i, imem_if.IMEM_ADDR, FLUSH, exp_addr); end
      step();
      checks++;
      if (IF_ID_PC !== exp_addr || IF_ID_IR !== exp_ir || IF_ID_VALID !== 1'b1) begin
        failures++;
        $display("FAIL seq_if_id[%0d]: got {%h,%h,%b} expected {%h,%h,1}",
                 i, IF_ID_PC, IF_ID_IR, IF_ID_VALID, exp_addr, exp_ir);
      end
    end
    checks++; if (imem_if.IMEM_ADDR !== 32'h10) begin failures++;
      $display("FAIL seq_final_addr: got %h expected 00000010", imem_if.IMEM_ADDR); end
  endtask

  // Stall on the ACK at 0x8, hold three cycles, then release.
  task automatic test_stall();
    reset_dut();
    imem_if.IMEM_ACK = 1'b1;
    imem_if.IMEM_RDATA = 32'h1111_0013;
    step();
    imem_if.IMEM_RDATA = 32'h2222_0013;
    step();
    imem_if.IMEM_RDATA = 32'hABCD_0013;
    STALL = 1'b1;
    step();
    imem_if.IMEM_ACK = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_if.IMEM_REQ !== 1'b0 || imem_if.IMEM_ADDR !== 32'hC ||
          IF_ID_PC !== 32'h4 || IF_ID_IR !== 32'h2222_0013 || IF_ID_VALID !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got req %b addr %h if_id {%h,%h,%b} expected req 0 addr 0000000c if_id {00000004,22220013,1}",
                 i, imem_if.IMEM_REQ, imem_if.IMEM_ADDR, IF_ID_PC, IF_ID_IR, IF_ID_VALID);
      end
      step();
    end
    checks++; if (imem_if.IMEM_REQ !== 1'b0 || IF_ID_PC !== 32'h4) begin failures++;
      $display("FAIL stall_hold_last: got req %b pc %h expected req 0 pc 00000004",
               imem_if.IMEM_REQ, IF_ID_PC); end
    STALL = 1'b0;
    step();
    checks++;
    if (IF_ID_PC !== 32'h8 || IF_ID_IR !== 32'hABCD_0013 || IF_ID_VALID !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got {%h,%h,%b} expected {00000008,abcd0013,1}",
               IF_ID_PC, IF_ID_IR, IF_ID_VALID);
    end
    checks++; if (imem_if.IMEM_REQ !== 1'b1 || imem_if.IMEM_ADDR !== 32'hC) begin failures++;
      $display("FAIL stall_next_addr: got req %b addr %h expected req 1 addr 0000000c",
               imem_if.IMEM_REQ, imem_if.IMEM_ADDR); end
    // No ACK while stalled: IF/ID holds.
    STALL = 1'b1;
    step();
    checks++; if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'h8 || imem_if.IMEM_ADDR !== 32'hC) begin
      failures++;
      $display("FAIL noack_stall: got valid %b pc %h addr %h expected valid 1 pc 00000008 addr 0000000c",
               IF_ID_VALID, IF_ID_PC, imem_if.IMEM_ADDR); end
    // No ACK, no stall: bubble.
    STALL = 1'b0;
    step();
    checks++; if (IF_ID_VALID !== 1'b0 || imem_if.IMEM_ADDR !== 32'hC) begin failures++;
      $display("FAIL noack_bubble: got valid %b addr %h expected valid 0 addr 0000000c",
               IF_ID_VALID, imem_if.IMEM_ADDR); end
  endtask

  // Branch redirect with the 0x20 request unacknowledged, then a JALR in DISCARD.
  task automatic test_branch_redirect();
    reset_dut();
    imem_if.IMEM_ACK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_if.IMEM_RDATA = 32'h0000_0013 + 32'(i << 20);
      step();
    end
    imem_if.IMEM_ACK = 1'b0;
    EX_VALID   = 1'b1;
    PC_SOURCE  = 2'b10;
    BRANCH_TGT = 32'h103;
    #1;
    checks++; if (FLUSH !== 1'b1 || imem_if.IMEM_ADDR !== 32'h20) begin failures++;
      $display("FAIL br_flush: got flush %b addr %h expected flush 1 addr 00000020",
               FLUSH, imem_if.IMEM_ADDR); end
    step();
    EX_VALID = 1'b0;
    PC_SOURCE = 2'b00;
    #1;
    checks++;
    if (IF_ID_VALID !== 1'b0 || imem_if.IMEM_REQ !== 1'b0 ||
        imem_if.IMEM_ADDR !== 32'h100 || FLUSH !== 1'b0) begin
      failures++;
      $display("FAIL br_discard: got valid %b req %b addr %h flush %b expected valid 0 req 0 addr 00000100 flush 0",
               IF_ID_VALID, imem_if.IMEM_REQ, imem_if.IMEM_ADDR, FLUSH);
    end
    // Second redirect while still discarding.
    EX_VALID  = 1'b1;
    PC_SOURCE = 2'b01;
    JALR_TGT  = 32'h202;
    step();
    EX_VALID  = 1'b0;
    PC_SOURCE = 2'b00;
    checks++; if (imem_if.IMEM_REQ !== 1'b0 || imem_if.IMEM_ADDR !== 32'h200) begin failures++;
      $display("FAIL jalr_in_discard: got req %b addr %h expected req 0 addr 00000200",
               imem_if.IMEM_REQ, imem_if.IMEM_ADDR); end
    // Late response for the squashed fetch is dropped.
    imem_if.IMEM_ACK   = 1'b1;
    imem_if.IMEM_RDATA = 32'hDEAD_BEEF;
    step();
    imem_if.IMEM_RDATA = 32'h0050_0013;
    checks++;
    if (IF_ID_VALID !== 1'b0 || imem_if.IMEM_REQ !== 1'b1 || imem_if.IMEM_ADDR !== 32'h200) begin
      failures++;
      $display("FAIL late_ack_drop: got valid %b req %b addr %h expected valid 0 req 1 addr 00000200",
               IF_ID_VALID, imem_if.IMEM_REQ, imem_if.IMEM_ADDR);
    end
    step();
    checks++;
    if (IF_ID_PC !== 32'h200 || IF_ID_IR !== 32'h0050_0013 || IF_ID_VALID !== 1'b1) begin
      failures++;
      $display("FAIL after_discard: got {%h,%h,%b} expected {00000200,00500013,1}",
               IF_ID_PC, IF_ID_IR, IF_ID_VALID);
    end
  endtask

  // JAL redirect coincident with ACK and STALL: data dropped, skid left empty.
  task automatic test_jal_ack_stall();
    reset_dut();
    imem_if.IMEM_ACK   = 1'b1;
    imem_if.IMEM_RDATA = 32'h0010_0013;
    step();
    STALL     = 1'b1;
    EX_VALID  = 1'b1;
    PC_SOURCE = 2'b11;
    JAL_TGT   = 32'h40;
    imem_if.IMEM_RDATA = 32'h0BAD_0013;
    #1;
    checks++; if (FLUSH !== 1'b1) begin failures++;
      $display("FAIL jal_flush: got %b expected 1", FLUSH); end
    step();
    EX_VALID  = 1'b0;
    PC_SOURCE = 2'b00;
    imem_if.IMEM_ACK = 1'b0;
    checks++;
    if (imem_if.IMEM_REQ !== 1'b1 || imem_if.IMEM_ADDR !== 32'h40 || IF_ID_VALID !== 1'b0) begin
      failures++;
      $display("FAIL jal_state: got req %b addr %h valid %b expected req 1 addr 00000040 valid 0",
               imem_if.IMEM_REQ, imem_if.IMEM_ADDR, IF_ID_VALID);
    end
    STALL = 1'b0;
    step();
    checks++; if (IF_ID_VALID !== 1'b0) begin failures++;
      $display("FAIL jal_skid_empty: got valid %b pc %h ir %h expected valid 0",
               IF_ID_VALID, IF_ID_PC, IF_ID_IR); end
    imem_if.IMEM_ACK   = 1'b1;
    imem_if.IMEM_RDATA = 32'h0040_0013;
    step();
    checks++;
    if (IF_ID_PC !== 32'h40 || IF_ID_IR !== 32'h0040_0013 || IF_ID_VALID !== 1'b1) begin
      failures++;
      $display("FAIL jal_target_fetch: got {%h,%h,%b} expected {00000040,00400013,1}",
               IF_ID_PC, IF_ID_IR, IF_ID_VALID);
    end
  endtask

  // PC wraps from 0xFFFFFFFC to 0; the unaligned target is forced aligned.
  task automatic test_wrap();
    reset_dut();
    imem_if.IMEM_ACK = 1'b1;
    EX_VALID  = 1'b1;
    PC_SOURCE = 2'b11;
    JAL_TGT   = 32'hFFFF_FFFF;
    step();
    EX_VALID  = 1'b0;
    PC_SOURCE = 2'b00;
    checks++; if (imem_if.IMEM_ADDR !== 32'hFFFF_FFFC || imem_if.IMEM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL wrap_start: got addr %h req %b expected addr fffffffc req 1",
               imem_if.IMEM_ADDR, imem_if.IMEM_REQ); end
    imem_if.IMEM_RDATA = 32'h0FF0_0013;
    step();
    checks++; if (imem_if.IMEM_ADDR !== 32'h0 || IF_ID_PC !== 32'hFFFF_FFFC) begin failures++;
      $display("FAIL wrap_next: got addr %h if_id_pc %h expected addr 00000000 if_id_pc fffffffc",
               imem_if.IMEM_ADDR, IF_ID_PC); end
  endtask

  // Reset asserted mid-HOLD takes effect without a clock edge.
  task automatic test_async_reset();
    reset_dut();
    imem_if.IMEM_ACK   = 1'b1;
    imem_if.IMEM_RDATA = 32'h0AAA_0013;
    step();
    STALL = 1'b1;
    imem_if.IMEM_RDATA = 32'h0BBB_0013;
    step();
    imem_if.IMEM_ACK = 1'b0;
    checks++; if (imem_if.IMEM_REQ !== 1'b0 || IF_ID_VALID !== 1'b1) begin failures++;
      $display("FAIL pre_reset_hold: got req %b valid %b expected req 0 valid 1",
               imem_if.IMEM_REQ, IF_ID_VALID); end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (imem_if.IMEM_REQ !== 1'b1 || imem_if.IMEM_ADDR !== 32'h0 || IF_ID_PC !== 32'h0 ||
        IF_ID_IR !== 32'h0000_0013 || IF_ID_VALID !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got req %b addr %h if_id {%h,%h,%b} expected req 1 addr 00000000 if_id {00000000,00000013,0}",
               imem_if.IMEM_REQ, imem_if.IMEM_ADDR, IF_ID_PC, IF_ID_IR, IF_ID_VALID);
    end
    STALL = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    // Response right after reset is treated as a fresh ACK.
    imem_if.IMEM_ACK   = 1'b1;
    imem_if.IMEM_RDATA = 32'h2222_0013;
    step();
    checks++;
    if (IF_ID_PC !== 32'h0 || IF_ID_IR !== 32'h2222_0013 || IF_ID_VALID !== 1'b1 ||
        imem_if.IMEM_ADDR !== 32'h4) begin
      failures++;
      $display("FAIL post_reset_ack: got {%h,%h,%b} addr %h expected {00000000,22220013,1} addr 00000004",
               IF_ID_PC, IF_ID_IR, IF_ID_VALID, imem_if.IMEM_ADDR);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    set_defaults();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_redirect();
    test_jal_ack_stall();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
